// File: rtl/sd_spi_led_alarm_mc_if.sv
// Alarm bus: error inputs, mask and clear towards the block; LED, sticky flags
// and the event counter back out.
interface sd_spi_led_alarm_mc_if #(
  parameter int NUM_CH = 4,
  parameter int LED_W  = 6
);
  logic [NUM_CH-1:0] error_flag;
  logic [NUM_CH-1:0] err_mask;
  logic              clear;
  logic [LED_W-1:0]  led;
  logic [NUM_CH-1:0] err_sticky;
  logic [7:0]        err_count;

  modport master (
    output error_flag, err_mask, clear,
    input  led, err_sticky, err_count
  );

  modport slave (
    input  error_flag, err_mask, clear,
    output led, err_sticky, err_count
  );
endinterface

// File: rtl/sd_spi_led_alarm_mc.sv
// Error alarm: latches masked per-channel errors, counts rising-edge events,
// blinks the lowest failing channel number on led[1] and drives a heartbeat on led[2].
module sd_spi_led_alarm_mc #(
  parameter int NUM_CH   = 4,
  parameter int LED_W    = 6,
  parameter int TICK_DIV = 5000000
) (
  input logic                  clk,
  input logic                  reset_n,
  sd_spi_led_alarm_mc_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ON, OFF, GAP} blink_state_e;

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [PW-1:0]            pre_cnt;
  logic                     tick;
  logic [3:0]               hb_cnt;
  logic [NUM_CH-1:0]        eff;
  logic [NUM_CH-1:0]        prev_eff;
  logic                     evt;
  logic [NUM_CH-1:0]        sticky_q, sticky_d;
  logic [NUM_CH+LED_W-1:0]  sticky_ext;
  logic [7:0]               count_q, count_d;
  blink_state_e             state_q, state_d;
  logic [3:0]               phase_q, phase_d;
  logic [3:0]               code_q, code_d;
  logic [3:0]               pulses_q, pulses_d;
  logic [LED_W-1:0]         led_q, led_d;

  // Blink code is the 1-based index of the lowest latched channel.
  function automatic logic [3:0] lowest_code(input logic [NUM_CH-1:0] v);
    lowest_code = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (v[i]) lowest_code = 4'(i + 1);
    end
  endfunction

  assign eff        = bus.error_flag & ~bus.err_mask;
  assign evt        = |(eff & ~prev_eff);
  assign tick       = (pre_cnt == PW'(TICK_DIV - 1));
  assign sticky_ext = {{LED_W{1'b0}}, sticky_d};

  // Free-running prescaler producing one tick every TICK_DIV cycles.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  pre_cnt <= '0;
    else if (tick) pre_cnt <= '0;
    else           pre_cnt <= pre_cnt + 1'b1;
  end

  // Heartbeat tick counter; wraps 15->0 naturally in four bits.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  hb_cnt <= '0;
    else if (tick) hb_cnt <= hb_cnt + 4'd1;
  end

  // Sticky flags (set wins over clear) and the saturating event counter.
  always_comb begin
    sticky_d = bus.clear ? eff : (sticky_q | eff);
    count_d  = count_q;
    if (bus.clear)                    count_d = evt ? 8'd1 : 8'd0;
    else if (evt && count_q != 8'hFF) count_d = count_q + 8'd1;
  end

  // Error latch, counter and edge-detect history; history ignores clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_eff <= '0;
      sticky_q <= '0;
      count_q  <= '0;
    end else begin
      prev_eff <= eff;
      sticky_q <= sticky_d;
      count_q  <= count_d;
    end
  end

  // Blink FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      phase_q  <= '0;
      code_q   <= '0;
      pulses_q <= '0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      code_q   <= code_d;
      pulses_q <= pulses_d;
    end
  end

  // Blink FSM next state: moves only on ticks, clear or no errors forces IDLE.
  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    code_d   = code_q;
    pulses_d = pulses_q;
    if (bus.clear || sticky_q == '0) begin
      state_d  = IDLE;
      phase_d  = '0;
      pulses_d = '0;
    end else if (tick) begin
      case (state_q)
        IDLE: begin
          state_d  = ON;
          phase_d  = '0;
          pulses_d = '0;
          code_d   = lowest_code(sticky_q);
        end
        ON: begin
          if (phase_q == 4'd3) begin
            state_d  = OFF;
            phase_d  = '0;
            pulses_d = pulses_q + 4'd1;
          end else begin
            phase_d = phase_q + 4'd1;
          end
        end
        OFF: begin
          if (phase_q == 4'd3) begin
            state_d = (pulses_q < code_q) ? ON : GAP;
            phase_d = '0;
          end else begin
            phase_d = phase_q + 4'd1;
          end
        end
        GAP: begin
          if (phase_q == 4'd15) begin
            state_d = IDLE;
            phase_d = '0;
          end else begin
            phase_d = phase_q + 4'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // LED outputs computed from next-cycle values so the register tracks the FSM exactly.
  always_comb begin
    led_d    = '0;
    led_d[0] = |sticky_d;
    led_d[1] = (state_d == ON);
    led_d[2] = (tick && hb_cnt == 4'd15) ? ~led_q[2] : led_q[2];
    for (int b = 3; b < LED_W; b++) begin
      led_d[b] = sticky_ext[b-3];
    end
  end

  // LED output register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) led_q <= '0;
    else          led_q <= led_d;
  end

  assign bus.led        = led_q;
  assign bus.err_sticky = sticky_q;
  assign bus.err_count  = count_q;

endmodule
